cam_search_array: RTL and testbench

CAM_SEARCH_ARRAY -- requirements
Module: cam_search_array

---
 rtl/cam_pkg.sv | 23 ++
 rtl/cam_prio_enc.sv | 20 ++
 rtl/cam_search_array.sv | 152 +++++++++++++++
 tb/tb_cam_search_array.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared encodings for the CAM search array: operation codes and region selects.
package cam_pkg;

    typedef enum logic [2:0] {
        OP_WRITE    = 3'b000,
        OP_UPDATE   = 3'b001,
        OP_S1       = 3'b010,
        OP_S2       = 3'b011,
        OP_S2_ACC   = 3'b100,
        OP_S1_MASK  = 3'b101,
        OP_RSVD6    = 3'b110,
        OP_RSVD7    = 3'b111
    } cam_op_e;

    localparam logic SEL_CMP = 1'b0;
    localparam logic SEL_PPG = 1'b1;

    // Anything that is not a row write travels the search pipeline, reserved codes included.
    function automatic logic is_search(input cam_op_e op);
        return (op != OP_WRITE) && (op != OP_UPDATE);
    endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-lane priority encoder; idx is 0 when no lane is set.
module cam_prio_enc #(
    parameter int WIDTH = 16,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic             any,
    output logic [IW-1:0]    idx
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        any = |vec;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/cam_search_array.sv
// Two-region CAM row array with a two-stage search pipeline and write/update ops.
// Optional match encoder outputs are enabled with the CAM_MATCH_ENC_EN macro.
module cam_search_array
    import cam_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CMP_ROWS = 32,
    parameter int PPG_ROWS = 4,
    localparam int AW = $clog2((CMP_ROWS > PPG_ROWS) ? CMP_ROWS : PPG_ROWS)
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             chip_enable,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    addr_a,
    input  logic             sel_a,
    input  logic [AW-1:0]    addr_b,
    input  logic             sel_b,
    input  logic [1:0]       key,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] tag_in,
    input  logic             update_value,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] tag_out,
    output logic             write_done
`ifdef CAM_MATCH_ENC_EN
    ,
    output logic                     match_any,
    output logic [$clog2(WIDTH)-1:0] match_idx
`endif
);

    localparam int CAW = (CMP_ROWS > 1) ? $clog2(CMP_ROWS) : 1;
    localparam int PAW = (PPG_ROWS > 1) ? $clog2(PPG_ROWS) : 1;

    logic [WIDTH-1:0] cmp_mem [CMP_ROWS];
    logic [WIDTH-1:0] ppg_mem [PPG_ROWS];

    cam_op_e          req_op;
    logic             accept, out_stall, wr_en;
    logic [WIDTH-1:0] row_a, row_b, new_row;

    logic             s1_valid;
    cam_op_e          s1_op;
    logic [WIDTH-1:0] s1_row_a, s1_row_b, s1_tag;
    logic [1:0]       s1_key;

    logic [WIDTH-1:0] acc, hit_a, hit_b, result;

    function automatic logic in_range(input logic sel, input logic [AW-1:0] addr);
        return (sel == SEL_PPG) ? (32'(addr) < PPG_ROWS) : (32'(addr) < CMP_ROWS);
    endfunction

    function automatic logic [WIDTH-1:0] read_row(input logic sel, input logic [AW-1:0] addr);
        if (!in_range(sel, addr)) return '0;
        return (sel == SEL_PPG) ? ppg_mem[addr[PAW-1:0]] : cmp_mem[addr[CAW-1:0]];
    endfunction

    assign req_op    = cam_op_e'(op);
    assign out_stall = resp_valid & ~resp_ready;
    assign req_ready = ~(s1_valid & out_stall);
    assign accept    = req_valid & req_ready & chip_enable;
    assign wr_en     = accept & ~is_search(req_op) & in_range(sel_a, addr_a);

    // Reads see the array before any same-edge write, so no forwarding path exists.
    assign row_a   = read_row(sel_a, addr_a);
    assign row_b   = read_row(sel_b, addr_b);
    assign new_row = (req_op == OP_UPDATE)
                   ? ((row_a & ~tag_in) | ({WIDTH{update_value}} & tag_in))
                   : data_in;

    // NOTE: the array is datapath storage with no reset; only control state is cleared.
    always_ff @(posedge CLK) begin
        if (wr_en && rst) begin
            if (sel_a == SEL_PPG) ppg_mem[addr_a[PAW-1:0]] <= new_row;
            else                  cmp_mem[addr_a[CAW-1:0]] <= new_row;
        end
    end

    always_comb begin
        hit_a  = s1_row_a ~^ {WIDTH{s1_key[0]}};
        hit_b  = s1_row_b ~^ {WIDTH{s1_key[1]}};
        result = '0;
        case (s1_op)
            OP_S1:      result = hit_a;
            OP_S2:      result = hit_a & hit_b;
            OP_S2_ACC:  result = hit_a & hit_b & acc;
            OP_S1_MASK: result = hit_a & s1_tag;
            default:    result = '0;
        endcase
    end

`ifdef CAM_MATCH_ENC_EN
    logic                     enc_any;
    logic [$clog2(WIDTH)-1:0] enc_idx;

    cam_prio_enc #(.WIDTH(WIDTH)) u_prio_enc (
        .vec (result),
        .any (enc_any),
        .idx (enc_idx)
    );
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_op      <= OP_WRITE;
            s1_row_a   <= '0;
            s1_row_b   <= '0;
            s1_tag     <= '0;
            s1_key     <= '0;
            resp_valid <= 1'b0;
            tag_out    <= '0;
            acc        <= '0;
            write_done <= 1'b0;
`ifdef CAM_MATCH_ENC_EN
            match_any  <= 1'b0;
            match_idx  <= '0;
`endif
        end else begin
            write_done <= wr_en;

            if (!out_stall) begin
                resp_valid <= s1_valid;
                if (s1_valid) begin
                    tag_out <= result;
                    acc     <= result;
`ifdef CAM_MATCH_ENC_EN
                    match_any <= enc_any;
                    match_idx <= enc_idx;
`endif
                end
            end

            if (accept && is_search(req_op)) begin
                s1_valid <= 1'b1;
                s1_op    <= req_op;
                s1_row_a <= row_a;
                s1_row_b <= row_b;
                s1_tag   <= tag_in;
                s1_key   <= key;
            end else if (!out_stall) begin
                s1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cam_search_array.sv
// Directed self-checking bench for cam_search_array with hand-computed expectations.
module tb_cam_search_array;

    localparam logic [2:0] OP_WR  = 3'b000;
    localparam logic [2:0] OP_UP  = 3'b001;
    localparam logic [2:0] OP_S1  = 3'b010;
    localparam logic [2:0] OP_S2  = 3'b011;
    localparam logic [2:0] OP_SAC = 3'b100;
    localparam logic [2:0] OP_SMK = 3'b101;
    localparam logic [2:0] OP_R6  = 3'b110;
    localparam logic       CMP    = 1'b0;
    localparam logic       PPG    = 1'b1;

    logic        CLK = 1'b0;
    logic        rst;
    logic        chip_enable, req_valid, req_ready;
    logic [2:0]  op;
    logic [4:0]  addr_a, addr_b;
    logic        sel_a, sel_b;
    logic [1:0]  key;
    logic [15:0] data_in, tag_in;
    logic        update_value;
    logic        resp_valid, resp_ready;
    logic [15:0] tag_out;
    logic        write_done;
`ifdef CAM_MATCH_ENC_EN
    logic        match_any;
    logic [3:0]  match_idx;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    cam_search_array dut (
        .CLK          (CLK),
        .rst          (rst),
        .chip_enable  (chip_enable),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .op           (op),
        .addr_a       (addr_a),
        .sel_a        (sel_a),
        .addr_b       (addr_b),
        .sel_b        (sel_b),
        .key          (key),
        .data_in      (data_in),
        .tag_in       (tag_in),
        .update_value (update_value),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .tag_out      (tag_out),
        .write_done   (write_done)
`ifdef CAM_MATCH_ENC_EN
        ,
        .match_any    (match_any),
        .match_idx    (match_idx)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Presents one request for a single edge, then drops req_valid.
    task automatic issue(input logic [2:0] o, input logic [4:0] aa, input logic sa,
                         input logic [4:0] ab, input logic sb, input logic [1:0] k,
                         input logic [15:0] d, input logic [15:0] t, input logic uv);
        op = o; addr_a = aa; sel_a = sa; addr_b = ab; sel_b = sb;
        key = k; data_in = d; tag_in = t; update_value = uv;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; chip_enable = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        op = '0; addr_a = '0; sel_a = 1'b0; addr_b = '0; sel_b = 1'b0;
        key = '0; data_in = '0; tag_in = '0; update_value = 1'b0;
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_tag_out", tag_out, 0);
        check("rst_write_done", write_done, 0);
        tick(); tick();
        rst = 1'b1;
        check("rst_req_ready", req_ready, 1);

        // Write then search on the next cycle
        issue(OP_WR, 3, CMP, 0, CMP, 2'b00, 16'hF0F0, 0, 0);
        check("wr_done_pulse", write_done, 1);
        issue(OP_S1, 3, CMP, 0, CMP, 2'b01, 0, 0, 0);
        check("wr_done_once", write_done, 0);
        check("s1_not_yet", resp_valid, 0);
        tick();
        check("s1_valid", resp_valid, 1);
        check("s1_tag", tag_out, 16'hF0F0);
        tick();
        check("s1_consumed", resp_valid, 0);

        // Update sets low nibble
        issue(OP_UP, 3, CMP, 0, CMP, 2'b00, 0, 16'h000F, 1);
        check("upd_done", write_done, 1);
        issue(OP_S1, 3, CMP, 0, CMP, 2'b01, 0, 0, 0);
        tick();
        check("upd_s1_key1", tag_out, 16'hF0FF);
        issue(OP_S1, 3, CMP, 0, CMP, 2'b00, 0, 0, 0);
        tick();
        check("upd_s1_key0", tag_out, 16'h0F00);
`ifdef CAM_MATCH_ENC_EN
        check("enc_idx_0f00", match_idx, 8);
`endif

        // S2 then back-to-back S2_ACC
        issue(OP_WR, 1, PPG, 0, CMP, 2'b00, 16'hFF00, 0, 0);
        issue(OP_WR, 4, CMP, 0, CMP, 2'b00, 16'h3333, 0, 0);
        issue(OP_S2, 3, CMP, 1, PPG, 2'b11, 0, 0, 0);
        issue(OP_SAC, 4, CMP, 1, PPG, 2'b11, 0, 0, 0);
        check("s2_valid", resp_valid, 1);
        check("s2_tag", tag_out, 16'hF000);
`ifdef CAM_MATCH_ENC_EN
        check("enc_any_f000", match_any, 1);
        check("enc_idx_f000", match_idx, 12);
`endif
        tick();
        check("s2acc_valid", resp_valid, 1);
        check("s2acc_tag", tag_out, 16'h3000);

        issue(OP_SMK, 3, CMP, 0, CMP, 2'b01, 0, 16'h0FF0, 0);
        tick();
        check("s1mask_tag", tag_out, 16'h00F0);
        issue(OP_R6, 3, CMP, 0, CMP, 2'b01, 0, 16'hFFFF, 0);
        tick();
        check("rsvd_valid", resp_valid, 1);
        check("rsvd_tag", tag_out, 16'h0000);
`ifdef CAM_MATCH_ENC_EN
        check("enc_any_zero", match_any, 0);
        check("enc_idx_zero", match_idx, 0);
`endif
        tick();

        // Output stall with two searches in flight
        resp_ready = 1'b0;
        issue(OP_S1, 3, CMP, 0, CMP, 2'b01, 0, 0, 0);
        issue(OP_S1, 4, CMP, 0, CMP, 2'b00, 0, 0, 0);
        check("stall_first_valid", resp_valid, 1);
        check("stall_first_tag", tag_out, 16'hF0FF);
        check("stall_req_ready0", req_ready, 0);
        tick();
        check("stall_hold_tag1", tag_out, 16'hF0FF);
        check("stall_hold_ready1", req_ready, 0);
        tick();
        check("stall_hold_tag2", tag_out, 16'hF0FF);
        check("stall_hold_valid2", resp_valid, 1);
        resp_ready = 1'b1;
        tick();
        check("stall_second_valid", resp_valid, 1);
        check("stall_second_tag", tag_out, 16'hCCCC);
        check("stall_req_ready1", req_ready, 1);
        tick();
        check("stall_drained", resp_valid, 0);

        // Out-of-range ppg rows
        issue(OP_WR, 5, PPG, 0, CMP, 2'b00, 16'h1234, 0, 0);
        check("oor_no_done", write_done, 0);
        issue(OP_S1, 5, PPG, 0, CMP, 2'b01, 0, 0, 0);
        tick();
        check("oor_s1_key1", tag_out, 16'h0000);
        issue(OP_S1, 5, PPG, 0, CMP, 2'b00, 0, 0, 0);
        tick();
        check("oor_s1_key0", tag_out, 16'hFFFF);
        issue(OP_WR, 3, PPG, 0, CMP, 2'b00, 16'h5A5A, 0, 0);
        check("ppg_last_done", write_done, 1);
        issue(OP_S1, 3, PPG, 0, CMP, 2'b01, 0, 0, 0);
        tick();
        check("ppg_last_tag", tag_out, 16'h5A5A);

        // chip_enable low blocks requests
        chip_enable = 1'b0;
        issue(OP_WR, 3, CMP, 0, CMP, 2'b00, 16'h0000, 0, 0);
        check("ce_no_done", write_done, 0);
        chip_enable = 1'b1;
        issue(OP_S1, 3, CMP, 0, CMP, 2'b01, 0, 0, 0);
        tick();
        check("ce_row_kept", tag_out, 16'hF0FF);

        // Reset mid-search
        issue(OP_S2, 3, CMP, 1, PPG, 2'b11, 0, 0, 0);
        issue(OP_S1, 1, PPG, 0, CMP, 2'b01, 0, 0, 0);
        check("pre_rst_tag", tag_out, 16'hF000);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_tag", tag_out, 0);
        check("mid_rst_done", write_done, 0);
`ifdef CAM_MATCH_ENC_EN
        check("mid_rst_any", match_any, 0);
`endif
        tick();
        rst = 1'b1;
        check("post_rst_ready", req_ready, 1);
        tick();
        check("post_rst_discard", resp_valid, 0);
        issue(OP_S1, 1, PPG, 0, CMP, 2'b01, 0, 0, 0);
        tick();
        check("post_rst_ppg1", tag_out, 16'hFF00);
        issue(OP_S1, 3, CMP, 0, CMP, 2'b01, 0, 0, 0);
        tick();
        check("post_rst_cmp3", tag_out, 16'hF0FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
